// File: rtl/fifo_if.sv
// Signal bundle carrying every fifo port as a plain logic signal.
interface fifo_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  clk;
    logic                  reset_n;
    logic                  write_en;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;
endinterface

// File: rtl/fifo.sv
// Synchronous FIFO with registered read data, occupancy flags and
// single-cycle overflow/underflow error pulses.
module fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_ok, rd_ok;

    assign full         = (count_q == CNT_DEPTH);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_DEPTH - CNT_ONE);
    assign almost_empty = (count_q <= CNT_ONE);

    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    assign wr_ok = write_en && (!full || read_en);
    assign rd_ok = read_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        overflow_d  = write_en && full && !read_en;
        underflow_d = read_en && empty;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            data_out_d = mem[rd_ptr_q];
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for the fifo block.
module tb_fifo;

    fifo_if #(.DATA_WIDTH(16)) bus ();

    fifo #(
        .DATA_WIDTH(16),
        .DEPTH     (8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk         (bus.clk),
        .reset_n     (bus.reset_n),
        .write_en    (bus.write_en),
        .read_en     (bus.read_en),
        .data_in     (bus.data_in),
        .data_out    (bus.data_out),
        .full        (bus.full),
        .empty       (bus.empty),
        .almost_full (bus.almost_full),
        .almost_empty(bus.almost_empty),
        .overflow    (bus.overflow),
        .underflow   (bus.underflow)
    );

    int checks   = 0;
    int failures = 0;

    initial bus.clk = 1'b0;
    always #5 bus.clk = ~bus.clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge bus.clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        bus.write_en = 1'b1;
        bus.read_en  = 1'b0;
        bus.data_in  = d;
        tick();
        bus.write_en = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] exp);
        bus.write_en = 1'b0;
        bus.read_en  = 1'b1;
        tick();
        bus.read_en = 1'b0;
        check(tag, {16'h0, bus.data_out}, {16'h0, exp});
    endtask

    task automatic idle();
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        tick();
    endtask

    initial begin
        bus.reset_n  = 1'b0;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        bus.data_in  = 16'h0;
        #2;
        check("rst_empty",    {31'h0, bus.empty},        32'd1);
        check("rst_aempty",   {31'h0, bus.almost_empty}, 32'd1);
        check("rst_full",     {31'h0, bus.full},         32'd0);
        check("rst_afull",    {31'h0, bus.almost_full},  32'd0);
        check("rst_dout",     {16'h0, bus.data_out},     32'd0);
        check("rst_ovf",      {31'h0, bus.overflow},     32'd0);
        check("rst_unf",      {31'h0, bus.underflow},    32'd0);
        tick();
        bus.reset_n = 1'b1;
        tick();

        // Basic write then read of 0x0001..0x0008
        for (int i = 1; i <= 8; i++) begin
            push(16'(i));
            if (i == 1) check("w1_aempty", {31'h0, bus.almost_empty}, 32'd1);
            if (i == 2) check("w2_aempty", {31'h0, bus.almost_empty}, 32'd0);
            if (i == 7) begin
                check("w7_afull", {31'h0, bus.almost_full}, 32'd1);
                check("w7_full",  {31'h0, bus.full},        32'd0);
            end
        end
        check("w8_full",  {31'h0, bus.full},        32'd1);
        check("w8_afull", {31'h0, bus.almost_full}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            pop_expect("basic_rd", 16'(i));
            if (i == 1) check("r1_full", {31'h0, bus.full}, 32'd0);
            if (i == 7) check("r7_empty", {31'h0, bus.empty}, 32'd0);
        end
        check("basic_empty", {31'h0, bus.empty}, 32'd1);

        // Underflow on empty
        bus.read_en = 1'b1;
        tick();
        bus.read_en = 1'b0;
        check("unf_pulse", {31'h0, bus.underflow}, 32'd1);
        check("unf_dout",  {16'h0, bus.data_out},  32'h0008);
        check("unf_empty", {31'h0, bus.empty},     32'd1);
        idle();
        check("unf_clear", {31'h0, bus.underflow}, 32'd0);

        // Overflow on full
        for (int i = 0; i < 8; i++) push(16'h0021 + 16'(i));
        push(16'hDEAD);
        check("ovf_pulse", {31'h0, bus.overflow}, 32'd1);
        check("ovf_full",  {31'h0, bus.full},     32'd1);
        idle();
        check("ovf_clear", {31'h0, bus.overflow}, 32'd0);
        for (int i = 0; i < 8; i++) pop_expect("ovf_rd", 16'h0021 + 16'(i));
        check("ovf_empty", {31'h0, bus.empty}, 32'd1);

        // Simultaneous read/write on empty
        bus.write_en = 1'b1;
        bus.read_en  = 1'b1;
        bus.data_in  = 16'h00AA;
        tick();
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        check("rwe_empty",  {31'h0, bus.empty},        32'd0);
        check("rwe_aempty", {31'h0, bus.almost_empty}, 32'd1);
        check("rwe_unf",    {31'h0, bus.underflow},    32'd1);
        check("rwe_dout",   {16'h0, bus.data_out},     32'h0028);
        pop_expect("rwe_rd", 16'h00AA);
        check("rwe_unf2",   {31'h0, bus.underflow},    32'd0);
        check("rwe_empty2", {31'h0, bus.empty},        32'd1);

        // Simultaneous read/write on full
        for (int i = 0; i < 8; i++) push(16'h0010 + 16'(i));
        bus.write_en = 1'b1;
        bus.read_en  = 1'b1;
        bus.data_in  = 16'h00BB;
        tick();
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        check("rwf_dout", {16'h0, bus.data_out}, 32'h0010);
        check("rwf_full", {31'h0, bus.full},     32'd1);
        check("rwf_ovf",  {31'h0, bus.overflow}, 32'd0);
        for (int i = 1; i < 8; i++) pop_expect("rwf_rd", 16'h0010 + 16'(i));
        pop_expect("rwf_bb", 16'h00BB);
        check("rwf_empty", {31'h0, bus.empty}, 32'd1);

        // Wrap: 5 in, 5 out, then 8 in without overflow
        for (int i = 0; i < 5; i++) push(16'h0100 + 16'(i));
        for (int i = 0; i < 5; i++) pop_expect("wrap_rd5", 16'h0100 + 16'(i));
        for (int i = 0; i < 8; i++) begin
            push(16'h0200 + 16'(i));
            check("wrap_ovf", {31'h0, bus.overflow}, 32'd0);
        end
        check("wrap_full", {31'h0, bus.full}, 32'd1);
        for (int i = 0; i < 8; i++) pop_expect("wrap_rd8", 16'h0200 + 16'(i));

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) push(16'h0300 + 16'(i));
        pop_expect("pre_rst_rd", 16'h0300);
        #2;
        bus.reset_n = 1'b0;
        #1;
        check("arst_empty", {31'h0, bus.empty},    32'd1);
        check("arst_dout",  {16'h0, bus.data_out}, 32'd0);
        check("arst_full",  {31'h0, bus.full},     32'd0);
        tick();
        bus.reset_n = 1'b1;
        push(16'h0055);
        check("post_rst_aempty", {31'h0, bus.almost_empty}, 32'd1);
        pop_expect("post_rst_rd", 16'h0055);
        check("post_rst_empty", {31'h0, bus.empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of storage entries; it is a power of two.
REQ-003 Parameter ADDR_WIDTH, default 3, SHALL set the pointer width, equal to log2(DEPTH).
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 write_en  input  1  SHALL be the write request, sampled on the clk rising edge.
REQ-007 read_en  input  1  SHALL be the read request, sampled on the clk rising edge.
REQ-008 data_in  input  DATA_WIDTH  SHALL carry the write data.
REQ-009 data_out  output  DATA_WIDTH  SHALL carry the registered read data.
REQ-010 full  output  1  SHALL be high when count == DEPTH.
REQ-011 empty  output  1  SHALL be high when count == 0.
REQ-012 almost_full  output  1  SHALL be high when count >= DEPTH-1.
REQ-013 almost_empty  output  1  SHALL be high when count <= 1.
REQ-014 overflow  output  1  SHALL be a registered error pulse for a rejected write.
REQ-015 underflow  output  1  SHALL be a registered error pulse for a rejected read.
REQ-016 The signal bundle fifo_if SHALL contain all twelve ports above as plain logic signals, with matching names and widths.

Function
REQ-017 The block SHALL be a synchronous FIFO with write pointer wr_ptr and read pointer rd_ptr, each ADDR_WIDTH bits, and an occupancy count of ADDR_WIDTH+1 bits.
REQ-018 Flags full, empty, almost_full and almost_empty SHALL be combinational functions of count.
REQ-019 A write SHALL be accepted when write_en=1 and (full=0, or read_en=1 with full=1).
  - An accepted write stores data_in at mem[wr_ptr].
  - wr_ptr then increments modulo DEPTH.
REQ-020 A read SHALL be accepted when read_en=1 and empty=0.
  - An accepted read loads mem[rd_ptr] into data_out at that edge, giving 1-cycle read latency.
  - rd_ptr then increments modulo DEPTH.
REQ-021 data_out SHALL hold its previous value on any cycle without an accepted read.
REQ-022 count SHALL update as follows:
  - +1 on a write-only cycle.
  - -1 on a read-only cycle.
  - Unchanged when both a read and a write are accepted, or when neither is.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0 with no gap or data corruption.
REQ-024 Full with write_en=1 and read_en=1: both operations SHALL occur; count stays DEPTH; overflow stays 0.
REQ-025 Empty with write_en=1 and read_en=1: the write SHALL be accepted and the read rejected; count becomes 1; underflow pulses; data_out is unchanged.
REQ-026 overflow SHALL go high for exactly the one cycle following an edge with write_en=1, full=1 and read_en=0; memory and pointers stay unchanged.
REQ-027 underflow SHALL go high for exactly the one cycle following an edge with read_en=1 and empty=1; rd_ptr and data_out stay unchanged.
REQ-028 overflow and underflow SHALL be low in every cycle not covered by REQ-025 to REQ-027.
REQ-029 Data SHALL be returned in exact write order (first in, first out).

Reset
REQ-030 reset_n=0 SHALL immediately, without waiting for a clock edge:
  - Clear wr_ptr, rd_ptr and count to 0.
  - Clear data_out, overflow and underflow to 0.
  - As a result: empty=1, almost_empty=1, full=0, almost_full=0.
REQ-031 Memory contents are not required to be cleared by reset.
REQ-032 Reset asserted mid-operation SHALL discard all stored entries; the first read after release returns the first word written after release.
REQ-033 Operations SHALL resume on the first rising clk edge after reset_n returns high.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
  - Basic write/read: after reset, write 0x0001..0x0008 (8 words) -> full=1 and almost_full=1 after the 8th write; 8 reads -> data_out 0x0001..0x0008 in order, each one cycle after its read; then empty=1.
  - Underflow: read_en=1 on an empty FIFO for 1 cycle -> underflow=1 for exactly one cycle; data_out and empty=1 unchanged.
  - Overflow: fill with 8 words, then write 0xDEAD -> overflow=1 for one cycle; subsequent 8 reads return the original 8 words and never 0xDEAD.
  - Simultaneous read/write on empty: write_en=read_en=1, data_in=0x00AA -> count=1, empty=0, almost_empty=1, underflow pulses; the next read returns 0x00AA.
  - Simultaneous read/write on full: FIFO holds 0x0010..0x0017; write 0x00BB with read -> data_out=0x0010, full stays 1, overflow=0; draining returns 0x0011..0x0017 then 0x00BB.
  - Wrap and reset: 5 writes, 5 reads, 8 writes with no overflow, in order; then assert reset_n mid-stream -> empty=1 and data_out=0 immediately.
